io_fifo_buffer: RTL
===================

Name: io_fifo_buffer

Overview:
Parametrised multi-entry successor to the single-register IO write buffer. It is a synchronous FIFO with show-ahead read, full/empty/count status and a synchronous flush. It sits between the CPU's memory-mapped IO write path and slow IO consumers (display, UART shifter), so bursts of stores are absorbed without stalling the core.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all contents; highest priority after reset
we  input  1  push request; writes din when accepted
din  input  WIDTH  push data
re  input  1  pop request; advances head when accepted
dout  output  WIDTH  head entry (show-ahead); 0 when empty
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  occupied entries, 0..DEPTH

Behaviour:
- Reset, with rst_n low and asynchronous:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Therefore empty = 1, full = 0, dout = 0.
  - Storage array is not reset.
- Storage and pointers:
  - Storage is mem[0..DEPTH-1], each WIDTH bits.
  - wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- Acceptance rules, evaluated each cycle:
  - push_ok = we & (~full | re)
  - pop_ok = re & ~empty
- Push at full with a simultaneous pop is accepted. Net count is unchanged and both pointers advance.
- Pop at empty with a simultaneous push is ignored; the push is accepted and count becomes 1. Data is not bypassed: dout shows the new entry the cycle after the push edge.
- Push while full without re: dropped; no pointer or storage change.
- Pop while empty: ignored.
- On a rising edge:
  - if push_ok: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1
  - if pop_ok: rd_ptr <= rd_ptr+1
  - count <= count + push_ok - pop_ok, computed in AW+1 bits; it never exceeds DEPTH or goes below 0.
- flush = 1 on an edge:
  - Sets wr_ptr, rd_ptr and count to 0.
  - Overrides we/re in that cycle; any push in that cycle is discarded.
- Outputs:
  - dout = empty ? 0 : mem[rd_ptr]. This is combinational from registered state, so it is valid in the same cycle as ~empty.
  - full and empty are decoded from registered count; no combinational path from we/re.
- Latency: a pushed word is visible on dout one cycle after its push edge when the FIFO was empty.
- Reset asserted mid-burst: all status returns to reset values immediately. Contents before reset are lost; they are never observable because dout = 0 when empty.

Optional Feature:
- Macro IO_FIFO_ERR_FLAG_EN.
- When defined, two extra outputs are added:
  - ovf (1 bit): sticky; set on the edge where we=1 & full=1 & re=0.
  - udf (1 bit): sticky; set on the edge where re=1 & empty=1.
  - Both reset to 0 on rst_n low and are cleared by flush. If flush and a set condition occur together, flush wins.
- When not defined: ports ovf and udf do not exist and the related logic is absent; all other behaviour is identical.

Test Plan:
- Reset with rst_n=0 mid-operation after 3 pushes -> empty=1, full=0, count=0, dout=0 immediately, without waiting for a clk edge.
- Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 -> dout sequence 0x11,0x22,0x33; count 1,2,3,2,1,0; empty returns to 1.
- Push 8 words 0xA0..0xA7 (DEPTH=8) -> full=1, count=8. A 9th push 0xFF with re=0 is dropped. Draining gives 0xA0..0xA7, never 0xFF. With the macro, ovf=1.
- Full FIFO, we=1 din=0xBB and re=1 same cycle -> count stays 8, dout advances to 0xA1. 0xBB emerges last after wrap-around; wr_ptr and rd_ptr wrap to 0.
- Empty FIFO, we=1 din=0x5A and re=1 same cycle -> count=1, dout=0x5A next cycle. With the macro, udf=1.
- 4 entries loaded, then flush=1 with we=1 din=0x77 -> next cycle count=0, empty=1, dout=0, 0x77 not stored. With the macro, ovf and udf are 0.

Source files
------------

// File: rtl/io_fifo_buffer_if.sv
// Bus bundle for io_fifo_buffer: push/pop handshake, flush and status.
// Optional error flags ovf/udf are present only with IO_FIFO_ERR_FLAG_EN.
interface io_fifo_buffer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic             flush;
   logic             we;
   logic [WIDTH-1:0] din;
   logic             re;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic [AW:0]      count;
`ifdef IO_FIFO_ERR_FLAG_EN
   logic             ovf;
   logic             udf;

   modport master (
      output flush, we, din, re,
      input  dout, full, empty, count, ovf, udf
   );

   modport slave (
      input  flush, we, din, re,
      output dout, full, empty, count, ovf, udf
   );
`else
   modport master (
      output flush, we, din, re,
      input  dout, full, empty, count
   );

   modport slave (
      input  flush, we, din, re,
      output dout, full, empty, count
   );
`endif
endinterface

// File: rtl/io_fifo_buffer.sv
// Show-ahead synchronous FIFO for the IO write path, with synchronous flush.
// Build option IO_FIFO_ERR_FLAG_EN adds sticky overflow/underflow flags.
module io_fifo_buffer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   io_fifo_buffer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             full_c;
   logic             empty_c;
   logic             push_ok;
   logic             pop_ok;

   // Status decode from registered occupancy only.
   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == CW'(0));

   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign push_ok = bus.we & (~full_c | bus.re);
   assign pop_ok  = bus.re & ~empty_c;

   // Pointer and occupancy update; flush overrides any push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage write; contents are never reset since empty masks dout.
   always_ff @(posedge clk) begin
      if (push_ok && !bus.flush) mem[wr_ptr] <= bus.din;
   end

   assign bus.dout  = empty_c ? '0 : mem[rd_ptr];
   assign bus.full  = full_c;
   assign bus.empty = empty_c;
   assign bus.count = count_q;

`ifdef IO_FIFO_ERR_FLAG_EN
   logic ovf_q;
   logic udf_q;

   // Sticky error flags; flush clears them even if a set condition coincides.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else if (bus.flush) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.we && full_c && !bus.re) ovf_q <= 1'b1;
         if (bus.re && empty_c)           udf_q <= 1'b1;
      end
   end

   assign bus.ovf = ovf_q;
   assign bus.udf = udf_q;
`endif

endmodule
